// File: rtl/wb_write_queue_if.sv
// wb_write_queue_if: enqueue, register-file write and bypass signals of the writeback queue
interface wb_write_queue_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int CW   = 3
);
  logic            enq_valid;
  logic            enq_ready;
  logic [AW-1:0]   enq_rd;
  logic [XLEN-1:0] enq_data;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] writedata;
  logic            regwrite;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            hit1;
  logic            hit2;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;
  logic [CW-1:0]   count;
  modport master (
    output enq_valid, enq_rd, enq_data, rs1, rs2,
    input  enq_ready, rd, writedata, regwrite, hit1, hit2, fwd1, fwd2, count
  );
  modport slave (
    input  enq_valid, enq_rd, enq_data, rs1, rs2,
    output enq_ready, rd, writedata, regwrite, hit1, hit2, fwd1, fwd2, count
  );
endinterface

// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order register writeback FIFO retiring one write per cycle, with youngest-entry read bypass
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input logic clk,
  input logic rst_n,
  wb_write_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0]   rd_mem_q [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d, idx;
  logic [CW-1:0]   count_q, count_d;
  logic            enq_fire, alloc, deq, h1, h2;
  logic [XLEN-1:0] f1, f2;
  assign enq_fire = bus.enq_valid && bus.enq_ready;
  assign alloc    = enq_fire && (bus.enq_rd != '0);
  assign deq      = count_q != '0;
  assign head_d   = deq ? head_q + 1'b1 : head_q;
  assign tail_d   = alloc ? tail_q + 1'b1 : tail_q;
  assign count_d  = count_q + CW'(alloc) - CW'(deq);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (alloc) begin
      rd_mem_q[tail_q]   <= bus.enq_rd;
      data_mem_q[tail_q] <= bus.enq_data;
    end
  // Scan oldest to youngest so the last match (nearest tail) wins.
  always_comb begin
    h1  = 1'b0;
    h2  = 1'b0;
    f1  = '0;
    f2  = '0;
    idx = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q && bus.rs1 != '0 && rd_mem_q[idx] == bus.rs1) begin
        h1 = 1'b1;
        f1 = data_mem_q[idx];
      end
      if (CW'(k) < count_q && bus.rs2 != '0 && rd_mem_q[idx] == bus.rs2) begin
        h2 = 1'b1;
        f2 = data_mem_q[idx];
      end
    end
  end
  assign bus.enq_ready = count_q != CW'(DEPTH);
  assign bus.regwrite  = deq;
  assign bus.rd        = deq ? rd_mem_q[head_q] : '0;
  assign bus.writedata = deq ? data_mem_q[head_q] : '0;
  assign bus.hit1      = h1;
  assign bus.hit2      = h2;
  assign bus.fwd1      = f1;
  assign bus.fwd2      = f2;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed scenario tasks for the writeback queue
module tb_wb_write_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  wb_write_queue_if #(.XLEN(32), .AW(5), .CW(3)) bus ();
  wb_write_queue #(.DEPTH(4), .XLEN(32), .AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic enq(input logic [4:0] r, input logic [31:0] d);
    bus.enq_valid = 1'b1;
    bus.enq_rd    = r;
    bus.enq_data  = d;
  endtask
  task automatic idle();
    bus.enq_valid = 1'b0;
    bus.enq_rd    = '0;
    bus.enq_data  = '0;
  endtask
  task automatic test_reset();
    idle();
    bus.rs1 = 5'd3;
    bus.rs2 = 5'd0;
    rst_n = 1'b0;
    step();
    step();
    checks++; if (bus.regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", bus.regwrite); end
    checks++; if (bus.rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", bus.rd); end
    checks++; if (bus.writedata !== 32'd0) begin errors++; $display("FAIL reset_writedata: got %h want 0", bus.writedata); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.enq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.enq_ready); end
    checks++; if (bus.hit1 !== 1'b0 || bus.fwd1 !== 32'd0) begin errors++; $display("FAIL reset_bypass: got hit=%b fwd=%h want 0/0", bus.hit1, bus.fwd1); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_single();
    bus.rs1 = 5'd3;
    enq(5'd3, 32'hDEADBEEF);
    checks++; if (bus.enq_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", bus.enq_ready); end
    checks++; if (bus.hit1 !== 1'b0) begin errors++; $display("FAIL single_no_same_cycle_bypass: got %b want 0", bus.hit1); end
    step();
    idle();
    checks++; if (bus.regwrite !== 1'b1 || bus.rd !== 5'd3 || bus.writedata !== 32'hDEADBEEF || bus.count !== 3'd1)
      begin errors++; $display("FAIL single_head: got we=%b rd=%0d wd=%h cnt=%0d want 1/3/deadbeef/1", bus.regwrite, bus.rd, bus.writedata, bus.count); end
    checks++; if (bus.hit1 !== 1'b1 || bus.fwd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_bypass: got hit=%b fwd=%h want 1/deadbeef", bus.hit1, bus.fwd1); end
    step();
    checks++; if (bus.regwrite !== 1'b0 || bus.count !== 3'd0 || bus.rd !== 5'd0 || bus.writedata !== 32'd0)
      begin errors++; $display("FAIL single_drained: got we=%b cnt=%0d rd=%0d wd=%h want 0/0/0/0", bus.regwrite, bus.count, bus.rd, bus.writedata); end
    checks++; if (bus.hit1 !== 1'b0 || bus.fwd1 !== 32'd0) begin errors++; $display("FAIL single_bypass_gone: got hit=%b fwd=%h want 0/0", bus.hit1, bus.fwd1); end
  endtask
  task automatic test_x0_discard();
    bus.rs1 = 5'd0;
    enq(5'd0, 32'h1234);
    checks++; if (bus.enq_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b want 1", bus.enq_ready); end
    step();
    idle();
    checks++; if (bus.count !== 3'd0 || bus.regwrite !== 1'b0) begin errors++; $display("FAIL x0_discard: got cnt=%0d we=%b want 0/0", bus.count, bus.regwrite); end
    checks++; if (bus.hit1 !== 1'b0) begin errors++; $display("FAIL x0_hit: got %b want 0", bus.hit1); end
    step();
    checks++; if (bus.regwrite !== 1'b0) begin errors++; $display("FAIL x0_later: got we=%b want 0", bus.regwrite); end
  endtask
  task automatic test_stream_wrap();
    for (int i = 1; i <= 6; i++) begin
      enq(5'(i), 32'h100 + 32'(i));
      checks++; if (bus.enq_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, bus.enq_ready); end
      step();
      checks++; if (bus.regwrite !== 1'b1 || bus.rd !== 5'(i) || bus.writedata !== 32'h100 + 32'(i) || bus.count > 3'd2)
        begin errors++; $display("FAIL stream_retire[%0d]: got we=%b rd=%0d wd=%h cnt=%0d want 1/%0d/%h/<=2", i, bus.regwrite, bus.rd, bus.writedata, bus.count, i, 32'h100 + 32'(i)); end
    end
    idle();
    step();
    checks++; if (bus.regwrite !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL stream_end: got we=%b cnt=%0d want 0/0", bus.regwrite, bus.count); end
  endtask
  task automatic test_youngest_bypass();
    bus.rs1 = 5'd5;
    bus.rs2 = 5'd5;
    enq(5'd5, 32'hA);
    step();
    enq(5'd5, 32'hB);
    checks++; if (bus.hit1 !== 1'b1 || bus.hit2 !== 1'b1 || bus.fwd1 !== 32'hA || bus.fwd2 !== 32'hA)
      begin errors++; $display("FAIL bypass_first: got %b/%b %h/%h want 1/1 a/a", bus.hit1, bus.hit2, bus.fwd1, bus.fwd2); end
    step();
    idle();
    checks++; if (bus.hit1 !== 1'b1 || bus.hit2 !== 1'b1 || bus.fwd1 !== 32'hB || bus.fwd2 !== 32'hB || bus.writedata !== 32'hB)
      begin errors++; $display("FAIL bypass_second: got %b/%b %h/%h wd=%h want 1/1 b/b b", bus.hit1, bus.hit2, bus.fwd1, bus.fwd2, bus.writedata); end
    step();
    checks++; if (bus.hit1 !== 1'b0 || bus.hit2 !== 1'b0 || bus.fwd1 !== 32'd0 || bus.fwd2 !== 32'd0)
      begin errors++; $display("FAIL bypass_retired: got %b/%b %h/%h want 0/0 0/0", bus.hit1, bus.hit2, bus.fwd1, bus.fwd2); end
  endtask
  task automatic test_simultaneous();
    bus.rs1 = 5'd7;
    bus.rs2 = 5'd9;
    enq(5'd7, 32'h77);
    step();
    enq(5'd9, 32'h99);
    checks++; if (bus.count !== 3'd1 || bus.rd !== 5'd7 || bus.hit1 !== 1'b1 || bus.hit2 !== 1'b0)
      begin errors++; $display("FAIL simul_before: got cnt=%0d rd=%0d h1=%b h2=%b want 1/7/1/0", bus.count, bus.rd, bus.hit1, bus.hit2); end
    step();
    idle();
    checks++; if (bus.count !== 3'd1 || bus.rd !== 5'd9 || bus.writedata !== 32'h99)
      begin errors++; $display("FAIL simul_after: got cnt=%0d rd=%0d wd=%h want 1/9/99", bus.count, bus.rd, bus.writedata); end
    checks++; if (bus.hit1 !== 1'b0 || bus.hit2 !== 1'b1 || bus.fwd2 !== 32'h99)
      begin errors++; $display("FAIL simul_bypass: got h1=%b h2=%b f2=%h want 0/1/99", bus.hit1, bus.hit2, bus.fwd2); end
    step();
  endtask
  task automatic test_reset_mid_drain();
    bus.rs1 = 5'd4;
    bus.rs2 = 5'd4;
    enq(5'd4, 32'h44);
    step();
    enq(5'd8, 32'h88);
    checks++; if (bus.regwrite !== 1'b1 || bus.hit1 !== 1'b1) begin errors++; $display("FAIL mid_pending: got we=%b h1=%b want 1/1", bus.regwrite, bus.hit1); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.regwrite !== 1'b0 || bus.count !== 3'd0 || bus.hit1 !== 1'b0 || bus.hit2 !== 1'b0 || bus.enq_ready !== 1'b1)
      begin errors++; $display("FAIL mid_async: got we=%b cnt=%0d h1=%b h2=%b rdy=%b want 0/0/0/0/1", bus.regwrite, bus.count, bus.hit1, bus.hit2, bus.enq_ready); end
    step();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.regwrite !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL mid_after[%0d]: got we=%b cnt=%0d want 0/0", i, bus.regwrite, bus.count); end
    end
  endtask
  initial begin
    idle();
    bus.rs1 = '0;
    bus.rs2 = '0;
    test_reset();
    test_single();
    test_x0_discard();
    test_stream_wrap();
    test_youngest_bypass();
    test_simultaneous();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
